// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - insert, wakeup, issue and flush signals of the issue queue
interface issue_queue_if #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PREG_W-1:0]    in_prs1;
  logic [PREG_W-1:0]    in_prs2;
  logic                 in_src1_wait;
  logic                 in_src2_wait;
  logic [PREG_W-1:0]    in_prd;
  logic                 in_rd_valid;
  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_prd;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [PREG_W-1:0]    iss_prd;
  logic                 iss_rd_valid;
  logic                 squash_i;
  logic [CW-1:0]        count_o;

  modport master (
    output in_valid, in_payload, in_prs1, in_prs2, in_src1_wait, in_src2_wait,
           in_prd, in_rd_valid, wb_valid, wb_prd, iss_ready, squash_i,
    input  in_ready, iss_valid, iss_payload, iss_prd, iss_rd_valid, count_o
  );

  modport slave (
    input  in_valid, in_payload, in_prs1, in_prs2, in_src1_wait, in_src2_wait,
           in_prd, in_rd_valid, wb_valid, wb_prd, iss_ready, squash_i,
    output in_ready, iss_valid, iss_payload, iss_prd, iss_rd_valid, count_o
  );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing in-order-age issue queue with busy-table wakeup
// Index 0 is the oldest entry; an entry is valid when its index is below the count.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic            clk,
  input  logic            rstn,
  issue_queue_if.slave    bus
);
  localparam int IW      = $clog2(DEPTH);
  localparam int CW      = IW + 1;
  localparam int PRFSIZE = 2 ** PREG_W;

  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
  logic [PAYLOAD_W-1:0] pay_n  [DEPTH];
  logic [PREG_W-1:0]    prs1_q [DEPTH];
  logic [PREG_W-1:0]    prs1_n [DEPTH];
  logic [PREG_W-1:0]    prs2_q [DEPTH];
  logic [PREG_W-1:0]    prs2_n [DEPTH];
  logic [PREG_W-1:0]    prd_q  [DEPTH];
  logic [PREG_W-1:0]    prd_n  [DEPTH];
  logic [DEPTH-1:0]     rdy1_q, rdy1_n, rdy2_q, rdy2_n, rdv_q, rdv_n;
  logic [DEPTH-1:0]     woke1, woke2;
  logic [CW-1:0]        cnt_q, cnt_n, ins_pos;
  logic [PRFSIZE-1:0]   busy_q, busy_n;
  logic [IW-1:0]        sel;
  logic                 found, in_rdy, iss_vld, ins, fire, ins_rdy1, ins_rdy2;

  assign in_rdy  = rstn && (cnt_q < CW'(DEPTH)) && !bus.squash_i;
  assign iss_vld = found && !bus.squash_i;
  assign ins     = bus.in_valid && in_rdy;
  assign fire    = iss_vld && bus.iss_ready;
  assign ins_pos = cnt_q - CW'(fire);

  assign bus.in_ready     = in_rdy;
  assign bus.iss_valid    = iss_vld;
  assign bus.iss_payload  = pay_q[sel];
  assign bus.iss_prd      = prd_q[sel];
  assign bus.iss_rd_valid = rdv_q[sel];
  assign bus.count_o      = cnt_q;

  // Descending scan so the lowest ready index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < cnt_q) && rdy1_q[i] && rdy2_q[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  // A source matching the current writeback counts as ready at insert.
  assign ins_rdy1 = !bus.in_src1_wait || !busy_q[bus.in_prs1] ||
                    (bus.wb_valid && (bus.wb_prd == bus.in_prs1));
  assign ins_rdy2 = !bus.in_src2_wait || !busy_q[bus.in_prs2] ||
                    (bus.wb_valid && (bus.wb_prd == bus.in_prs2));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke1[i] = rdy1_q[i] | (bus.wb_valid && (prs1_q[i] == bus.wb_prd));
      woke2[i] = rdy2_q[i] | (bus.wb_valid && (prs2_q[i] == bus.wb_prd));
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [IW-1:0] src;
      src = IW'(i);
      if (fire && (IW'(i) >= sel) && (i < DEPTH - 1)) src = IW'(i + 1);
      pay_n[i]  = pay_q[src];
      prs1_n[i] = prs1_q[src];
      prs2_n[i] = prs2_q[src];
      prd_n[i]  = prd_q[src];
      rdy1_n[i] = woke1[src];
      rdy2_n[i] = woke2[src];
      rdv_n[i]  = rdv_q[src];
      if (ins && (ins_pos == CW'(i))) begin
        pay_n[i]  = bus.in_payload;
        prs1_n[i] = bus.in_prs1;
        prs2_n[i] = bus.in_prs2;
        prd_n[i]  = bus.in_prd;
        rdy1_n[i] = ins_rdy1;
        rdy2_n[i] = ins_rdy2;
        rdv_n[i]  = bus.in_rd_valid;
      end
    end
  end

  // Clear before set so a same-cycle allocate of the written-back preg wins.
  always_comb begin
    busy_n = busy_q;
    if (bus.wb_valid) busy_n[bus.wb_prd] = 1'b0;
    if (ins && bus.in_rd_valid) busy_n[bus.in_prd] = 1'b1;
    cnt_n = cnt_q + CW'(ins) - CW'(fire);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else if (bus.squash_i) begin
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_n;
      busy_q <= busy_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      pay_q[i]  <= pay_n[i];
      prs1_q[i] <= prs1_n[i];
      prs2_q[i] <= prs2_n[i];
      prd_q[i]  <= prd_n[i];
    end
    rdy1_q <= rdy1_n;
    rdy2_q <= rdy2_n;
    rdv_q  <= rdv_n;
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - randomized and directed check of issue_queue against a queue-based model
module tb_issue_queue;
  localparam int DEPTH     = 8;
  localparam int PREG_W    = 6;
  localparam int PAYLOAD_W = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();
  issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] pay;
    int          prs1;
    int          prs2;
    bit          r1;
    bit          r2;
    int          prd;
    bit          rdv;
  } ent_t;

  ent_t mq[$];
  bit   mbusy[64];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msel();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // Reference model: age-ordered list, ready flags, busy bits.
  always @(posedge clk or negedge rstn) begin
    if (!rstn || bus.squash_i) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
    end else begin
      int   s;
      bit   do_ins, do_fire;
      ent_t e;
      s       = msel();
      do_fire = (s >= 0) && bus.iss_ready;
      do_ins  = bus.in_valid && (mq.size() < DEPTH);
      e.pay  = bus.in_payload;
      e.prs1 = int'(bus.in_prs1);
      e.prs2 = int'(bus.in_prs2);
      e.prd  = int'(bus.in_prd);
      e.rdv  = bus.in_rd_valid;
      e.r1   = !bus.in_src1_wait || !mbusy[e.prs1] || (bus.wb_valid && int'(bus.wb_prd) == e.prs1);
      e.r2   = !bus.in_src2_wait || !mbusy[e.prs2] || (bus.wb_valid && int'(bus.wb_prd) == e.prs2);
      foreach (mq[i]) begin
        if (bus.wb_valid && mq[i].prs1 == int'(bus.wb_prd)) mq[i].r1 = 1'b1;
        if (bus.wb_valid && mq[i].prs2 == int'(bus.wb_prd)) mq[i].r2 = 1'b1;
      end
      if (do_fire) mq.delete(s);
      if (do_ins) mq.push_back(e);
      if (bus.wb_valid) mbusy[bus.wb_prd] = 1'b0;
      if (do_ins && bus.in_rd_valid) mbusy[bus.in_prd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int s;
    bit exp_iv;
    s      = msel();
    exp_iv = rstn && (s >= 0) && !bus.squash_i;
    chk("in_ready", bus.in_ready, rstn && (mq.size() < DEPTH) && !bus.squash_i);
    chk("iss_valid", bus.iss_valid, exp_iv);
    chk("count_o", bus.count_o, mq.size());
    if (exp_iv) begin
      chk("iss_payload", bus.iss_payload, mq[s].pay);
      chk("iss_prd", bus.iss_prd, mq[s].prd);
      chk("iss_rd_valid", bus.iss_rd_valid, mq[s].rdv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_payload   = '0;
    bus.in_prs1      = '0;
    bus.in_prs2      = '0;
    bus.in_src1_wait = 1'b0;
    bus.in_src2_wait = 1'b0;
    bus.in_prd       = '0;
    bus.in_rd_valid  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_prd       = '0;
    bus.iss_ready    = 1'b0;
    bus.squash_i     = 1'b0;
  endtask

  task automatic set_ins(input logic [63:0] pay, input int p1, input bit w1,
                         input int p2, input bit w2, input int prd, input bit rdv);
    bus.in_valid     = 1'b1;
    bus.in_payload   = pay;
    bus.in_prs1      = PREG_W'(p1);
    bus.in_src1_wait = w1;
    bus.in_prs2      = PREG_W'(p2);
    bus.in_src2_wait = w2;
    bus.in_prd       = PREG_W'(prd);
    bus.in_rd_valid  = rdv;
  endtask

  logic [63:0] ord[7];
  int          wake_list[7];

  initial begin
    ord       = '{64'h100, 64'h101, 64'h102, 64'h104, 64'h105, 64'h106, 64'h107};
    wake_list = '{10, 11, 12, 14, 15, 16, 17};
    idle();
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_iss_valid", bus.iss_valid, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Ready-at-insert entry issues one cycle later.
    tick();
    set_ins(64'h33, 5, 1, 0, 0, 1, 0);
    bus.iss_ready = 1'b1;
    @(negedge clk);
    chk("r33_not_yet", bus.iss_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r33_valid", bus.iss_valid, 1);
    chk("r33_payload", bus.iss_payload, 64'h33);
    tick();

    // Consumer waits on producer's preg until writeback.
    set_ins(64'hA, 0, 0, 0, 0, 7, 1);
    bus.iss_ready = 1'b0;
    tick();
    set_ins(64'hB, 7, 1, 0, 0, 2, 0);
    tick();
    bus.in_valid  = 1'b0;
    bus.iss_ready = 1'b1;
    @(negedge clk);
    chk("r34_A", bus.iss_payload, 64'hA);
    tick();
    @(negedge clk);
    chk("r34_B_waiting", bus.iss_valid, 0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_prd   = 7;
    @(negedge clk);
    chk("r34_B_not_before", bus.iss_valid, 0);
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("r34_B_issue", bus.iss_valid, 1);
    chk("r34_B_payload", bus.iss_payload, 64'hB);
    tick();

    // Full queue, wake the middle entry, then drain in age order.
    for (int k = 0; k < 8; k++) begin
      set_ins(64'h10 + k, 0, 0, 0, 0, 10 + k, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_ins(64'h100 + k, 10 + k, 1, 0, 0, 0, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r35_full_in_ready", bus.in_ready, 0);
    chk("r35_full_count", bus.count_o, 8);
    chk("r35_none_ready", bus.iss_valid, 0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_prd   = 13;
    tick();
    bus.wb_valid  = 1'b0;
    bus.iss_ready = 1'b1;
    @(negedge clk);
    chk("r35_e3_valid", bus.iss_valid, 1);
    chk("r35_e3_payload", bus.iss_payload, 64'h103);
    tick();
    bus.iss_ready = 1'b0;
    @(negedge clk);
    chk("r35_count7", bus.count_o, 7);
    chk("r35_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 7; k++) begin
      bus.wb_valid = 1'b1;
      bus.wb_prd   = PREG_W'(wake_list[k]);
      tick();
    end
    bus.wb_valid  = 1'b0;
    bus.iss_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("r35_order", bus.iss_payload, ord[k]);
      tick();
    end

    // Oldest ready entry held while stalled, then younger ready entry.
    set_ins(64'h30, 0, 0, 0, 0, 30, 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.iss_ready = 1'b0;
    set_ins(64'hA0, 0, 0, 0, 0, 0, 0);
    tick();
    set_ins(64'hA1, 30, 1, 0, 0, 0, 0);
    tick();
    set_ins(64'hA2, 0, 0, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("r36_hold_valid", bus.iss_valid, 1);
      chk("r36_hold_payload", bus.iss_payload, 64'hA0);
      tick();
    end
    bus.iss_ready = 1'b1;
    @(negedge clk);
    chk("r36_first", bus.iss_payload, 64'hA0);
    tick();
    @(negedge clk);
    chk("r36_second", bus.iss_payload, 64'hA2);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_prd   = 30;
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("r36_last", bus.iss_payload, 64'hA1);
    tick();

    // Writeback in the insert cycle marks the source ready.
    set_ins(64'h90, 0, 0, 0, 0, 9, 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    set_ins(64'h91, 9, 1, 0, 0, 0, 0);
    bus.wb_valid = 1'b1;
    bus.wb_prd   = 9;
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("r37_valid", bus.iss_valid, 1);
    chk("r37_payload", bus.iss_payload, 64'h91);
    tick();

    // Squash empties queue and busy table.
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_ins(64'hC0 + k, 0, 0, 0, 0, 40 + k, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r38_count4", bus.count_o, 4);
    tick();
    bus.squash_i = 1'b1;
    @(negedge clk);
    chk("r38_sq_iss_valid", bus.iss_valid, 0);
    chk("r38_sq_in_ready", bus.in_ready, 0);
    tick();
    bus.squash_i = 1'b0;
    @(negedge clk);
    chk("r38_count0", bus.count_o, 0);
    chk("r38_iss_valid0", bus.iss_valid, 0);
    tick();
    set_ins(64'hD0, 40, 1, 41, 1, 0, 0);
    bus.iss_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("r38_busy_clear", bus.iss_valid, 1);
    chk("r38_payload", bus.iss_payload, 64'hD0);
    tick();

    // Random traffic on a small preg range so wakeups collide often.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid     = ($urandom_range(0, 99) < 60);
      bus.in_payload   = {$urandom, $urandom};
      bus.in_prs1      = PREG_W'($urandom_range(0, 15));
      bus.in_prs2      = PREG_W'($urandom_range(0, 15));
      bus.in_src1_wait = $urandom_range(0, 1) == 1;
      bus.in_src2_wait = $urandom_range(0, 1) == 1;
      bus.in_prd       = PREG_W'($urandom_range(0, 15));
      bus.in_rd_valid  = ($urandom_range(0, 99) < 70);
      bus.wb_valid     = ($urandom_range(0, 99) < 40);
      bus.wb_prd       = PREG_W'($urandom_range(0, 15));
      bus.iss_ready    = ($urandom_range(0, 99) < ((n < 1000) ? 30 : 70));
      bus.squash_i     = ($urandom_range(0, 199) == 0);
      if (n == 1500) rstn = 1'b0;
      if (n == 1503) rstn = 1'b1;
      tick();
    end
    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter PREG_W, default 6, physical register id width (PRFSIZE = 2**PREG_W).
REQ-003 SHALL have parameter PAYLOAD_W, default 64, opaque renamed-instruction payload width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  insert handshake from rename.
REQ-007 in_payload  in  PAYLOAD_W  renamed instruction, carried untouched.
REQ-008 in_prs1, in_prs2  in  PREG_W each  source pregs.
REQ-009 in_src1_wait, in_src2_wait  in  1 each  source needs a preg (rs valid AND renamed); 0 = operand already available.
REQ-010 in_prd, in_rd_valid  in  PREG_W / 1  destination preg and its validity.
REQ-011 wb_valid, wb_prd  in  1 / PREG_W  writeback wakeup broadcast.
REQ-012 iss_valid / iss_ready  out / in  1 / 1  issue handshake to execute.
REQ-013 iss_payload, iss_prd, iss_rd_valid  out  PAYLOAD_W / PREG_W / 1  issued entry fields.
REQ-014 squash_i  in  1  pipeline flush.
REQ-015 count_o  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Storage: collapsing queue, index 0 oldest; each entry holds payload, prs1/2, rdy1/2, prd, rd_valid.
REQ-017 Busy table: PRFSIZE bits; bit set on accepted insert with in_rd_valid at in_prd; cleared when wb_valid at wb_prd.
REQ-018 Same-cycle set and clear of same preg: set wins.
REQ-019 in_ready = (count_o < DEPTH) AND NOT squash_i; no insert-at-full bypass even if issuing that cycle.
REQ-020 Insert accepted when in_valid AND in_ready; entry written at index (count after this cycle's issue removal), visible next cycle.
REQ-021 Insert-time readiness: rdyN = NOT in_srcN_wait OR NOT busy[in_prsN] OR (wb_valid AND wb_prd == in_prsN).
REQ-022 Wakeup: every valid entry with prsN == wb_prd and wb_valid sets rdyN next cycle; wakeup-to-issue latency 1 cycle.
REQ-023 Insert-to-issue minimum latency 1 cycle (entry inserted in cycle N may issue in N+1).
REQ-024 Select: lowest-index valid entry with rdy1 AND rdy2; iss_valid = such entry exists; outputs combinational from selected entry.
REQ-025 Issue fires when iss_valid AND iss_ready; entries above selected index shift down one; count decrements.
REQ-026 iss_valid SHALL NOT depend on iss_ready; selected entry stays stable while iss_ready low unless an older entry becomes ready.
REQ-027 Simultaneous insert and issue: count unchanged; new entry placed at count-1 after collapse.
REQ-028 Insert of entry whose in_prd matches an in-queue source: that source already ready or waiting stays as is (busy only affects later lookups).
REQ-029 squash_i (synchronous): next cycle all entries invalid, count 0, busy table all clear; issue and insert in squash cycle suppressed (iss_valid forced 0).
REQ-030 count_o never exceeds DEPTH nor underflows; wrap impossible by construction.

Reset
REQ-031 rstn low: all entries invalid, busy table clear, count_o=0, iss_valid=0, in_ready=0 while asserted, 1 in first cycle after release.
REQ-032 Reset mid-operation discards all entries with no issue; payload registers need no reset.

Verification
REQ-033 Insert prs1=5 wait, prs2 no wait, busy[5]=0 -> iss_valid next cycle, iss_payload matches.
REQ-034 Insert prd=7 (A), then B waiting on 7; wb_prd=7 in cycle N -> B issues cycle N+1, not before.
REQ-035 Fill 8 entries, none ready -> in_ready=0, count_o=8; wb wakes entry 3 -> it issues, count_o=7, in_ready=1, order 0-2,4-7 preserved.
REQ-036 Entries 0 and 2 ready, iss_ready=0 two cycles -> iss_valid=1 holding entry 0; iss_ready=1 -> entry 0 then entry 1 (old 2) issued.
REQ-037 Insert waiting on prs=9 in same cycle wb_prd=9 -> rdy set at insert, issues next cycle.
REQ-038 4 entries queued, squash_i=1 -> next cycle count_o=0, iss_valid=0, busy clear (insert waiting on prior prd issues immediately).
